// File: rtl/intcode_bus_arbiter.sv
// Two-master arbiter for the intcode RAM / memory-mapped I/O bus; hides the RAM's one-cycle read latency.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin contention (default: master 0 fixed priority).
module intcode_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  // Handshake: each master holds req (with stable addr/we/wdata) until it sees a
  // one-cycle ack; lock is sampled in the ack cycle and covers the next transaction.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   lock_q;
  logic   we_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic   rr_pri;  // master that wins the next contention
`endif

  logic              any_req;
  logic              owner_req;
  logic              owner_lock;
  logic              winner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  assign dbg_state = state;

  always_comb begin
    owner_req  = owner ? m1_req  : m0_req;
    owner_lock = owner ? m1_lock : m0_lock;
    any_req    = m0_req | m1_req;
    winner     = 1'b0;
    if (lock_q && owner_req) begin
      winner = owner;
    end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = rr_pri;
`else
      winner = 1'b0;
`endif
    end else begin
      winner = m1_req;
    end
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    sel_we    = winner ? m1_we    : m0_we;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      lock_q      <= 1'b0;
      we_q        <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_pri      <= 1'b0;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A locked owner that no longer requests gives up its claim.
          if (lock_q && !owner_req) lock_q <= 1'b0;
          if (any_req) begin
            owner       <= winner;
            we_q        <= sel_we;
            mem_address <= sel_addr;
            mem_wdata   <= sel_wdata;
            mem_we      <= sel_we;
            mem_oe      <= ~sel_we;
`ifdef ARB_ROUND_ROBIN_EN
            rr_pri      <= ~winner;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            m0_ack      <= ~owner;
            m1_ack      <= owner;
            state       <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // RAM output is valid now, one cycle after the address was presented.
          if (owner) m1_rdata <= mem_rdata;
          else       m0_rdata <= mem_rdata;
          mem_address <= '0;
          mem_wdata   <= '0;
          mem_we      <= 1'b0;
          mem_oe      <= 1'b0;
          m0_ack      <= ~owner;
          m1_ack      <= owner;
          state       <= ACK;
        end
        ACK: begin
          lock_q <= owner_lock;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
